// File: rtl/hs32_mem_arbiter_if.sv
// hs32 memory request bus: execute/fetch initiator ports plus the SRAM-style memory port.
// slave = arbiter view, master = initiators and memory view.
interface hs32_mem_arbiter_if;
  logic [31:0] addr_x, dtw_x, dtrm_x;
  logic        rw_x, reqm_x, rdym_x;
  logic [31:0] addr_f, dtrm_f;
  logic        reqm_f, rdym_f;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_we, mem_ce;

  modport slave (
    input  addr_x, dtw_x, rw_x, reqm_x, addr_f, reqm_f, mem_din,
    output rdym_x, dtrm_x, rdym_f, dtrm_f, mem_addr, mem_dout, mem_we, mem_ce
  );
  modport master (
    output addr_x, dtw_x, rw_x, reqm_x, addr_f, reqm_f, mem_din,
    input  rdym_x, dtrm_x, rdym_f, dtrm_f, mem_addr, mem_dout, mem_we, mem_ce
  );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// Two-initiator (execute r/w, fetch read-only) arbiter onto one fixed-wait SRAM port.
// HS32_ARB_RR_EN selects round-robin tie-break; otherwise execute has fixed priority.
module hs32_mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  hs32_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, GAP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       grant_f;
  logic       pick_f;

`ifdef HS32_ARB_RR_EN
  logic last_f;

  // On a tie the port that did not win last time gets the grant.
  always_comb pick_f = bus.reqm_f && (!bus.reqm_x || !last_f);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         last_f <= 1'b1;
    else if (state == IDLE && (bus.reqm_x || bus.reqm_f)) last_f <= pick_f;
  end
`else
  always_comb pick_f = bus.reqm_f && !bus.reqm_x;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      grant_f      <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_dout <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_ce   <= 1'b0;
      bus.rdym_x   <= 1'b0;
      bus.rdym_f   <= 1'b0;
      bus.dtrm_x   <= '0;
      bus.dtrm_f   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.reqm_x || bus.reqm_f) begin
          grant_f      <= pick_f;
          bus.mem_addr <= pick_f ? bus.addr_f : bus.addr_x;
          bus.mem_dout <= bus.dtw_x;
          bus.mem_we   <= !pick_f && bus.rw_x;
          bus.mem_ce   <= 1'b1;
          cnt          <= 4'(WAIT_CYCLES - 1);
          state        <= ACCESS;
        end
        ACCESS: if (cnt == '0) begin
          if (!bus.mem_we) begin
            if (grant_f) bus.dtrm_f <= bus.mem_din;
            else         bus.dtrm_x <= bus.mem_din;
          end
          bus.mem_ce <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.rdym_x <= !grant_f;
          bus.rdym_f <= grant_f;
          state      <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: begin
          bus.rdym_x <= 1'b0;
          bus.rdym_f <= 1'b0;
          state      <= GAP;
        end
        // Dead cycle: the initiator's reqm drop has settled before the next arbitration.
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
